// File: rtl/axi_master_pkg.sv
// Shared types and AXI encodings for the FFT bridge initiator.
package axi_master_pkg;

    typedef enum logic [2:0] {
        M_IDLE,
        M_AW,
        M_W,
        M_B,
        M_WAIT,
        M_AR,
        M_R
    } master_fsm;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_2B    = 3'd1;
    localparam logic [2:0] SIZE_4B    = 3'd2;

endpackage

// File: rtl/axi_fft_master_if.sv
// AXI channel bundle between the FFT initiator and the FFT slave bridge.
interface axi_fft_master_if #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WDATA_WIDTH = 16,
    parameter int RDATA_WIDTH = 32,
    parameter int ID_WIDTH    = 2
);

    logic [ADDR_WIDTH-1:0]    awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic [ID_WIDTH-1:0]      awid;
    logic                     awvalid;
    logic                     awready;

    logic [WDATA_WIDTH-1:0]   wdata;
    logic [WDATA_WIDTH/8-1:0] wstrb;
    logic                     wvalid;
    logic                     wlast;
    logic                     wready;

    logic                     bvalid;
    logic [ID_WIDTH-1:0]      bid;
    logic                     bready;

    logic [ADDR_WIDTH-1:0]    araddr;
    logic [7:0]               arlen;
    logic [2:0]               arsize;
    logic [1:0]               arburst;
    logic [ID_WIDTH-1:0]      arid;
    logic                     arvalid;
    logic                     arready;

    logic [RDATA_WIDTH-1:0]   rdata;
    logic [ID_WIDTH-1:0]      rid;
    logic                     rvalid;
    logic                     rlast;
    logic                     rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awid, awvalid, input awready,
        output wdata, wstrb, wvalid, wlast, input wready,
        input  bvalid, bid, output bready,
        output araddr, arlen, arsize, arburst, arid, arvalid, input arready,
        input  rdata, rid, rvalid, rlast, output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awid, awvalid, output awready,
        input  wdata, wstrb, wvalid, wlast, output wready,
        output bvalid, bid, input bready,
        input  araddr, arlen, arsize, arburst, arid, arvalid, output arready,
        output rdata, rid, rvalid, rlast, input rready
    );

endinterface

// File: rtl/axi_master_wbuf.sv
// W-channel feeder: prefetches samples from a 1-cycle-latency buffer and
// holds the current beat stable across WREADY stalls.
module axi_master_wbuf #(
    parameter int WDATA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   entry,
    input  logic [7:0]             len_m1,
    input  logic                   wready,
    input  logic [WDATA_WIDTH-1:0] src_data,
    output logic                   wvalid,
    output logic [WDATA_WIDTH-1:0] wdata,
    output logic                   wlast,
    output logic                   src_rd,
    output logic [7:0]             src_addr,
    output logic                   last_hs
);

    logic                   valid_q;
    logic                   fresh_q;
    logic [7:0]             cnt_q;
    logic [WDATA_WIDTH-1:0] hold_q;
    logic                   hs;
    logic                   at_last;

    assign hs      = valid_q && wready;
    assign at_last = (cnt_q == len_m1);

    assign wvalid  = valid_q;
    assign wlast   = valid_q && at_last;
    assign last_hs = hs && at_last;

    // Next sample is fetched in the same cycle the current beat is accepted,
    // so its data lands exactly when the following beat is presented.
    assign src_rd   = entry || (hs && !at_last);
    assign src_addr = entry ? 8'd0 : cnt_q + 8'd1;

    // Freshly read data comes straight from the buffer; after that the copy
    // in hold_q keeps WDATA stable no matter what the buffer output does.
    assign wdata = fresh_q ? src_data : hold_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
            cnt_q   <= 8'd0;
            hold_q  <= '0;
        end else begin
            fresh_q <= src_rd;
            if (fresh_q) hold_q <= src_data;
            if (entry) begin
                valid_q <= 1'b1;
                cnt_q   <= 8'd0;
            end else if (hs) begin
                if (at_last) valid_q <= 1'b0;
                else         cnt_q   <= cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/axi_fft_master.sv
// AXI initiator: bursts samples into the FFT bridge, waits for the FFT,
// then bursts results back into the local result buffer.
module axi_fft_master
    import axi_master_pkg::*;
#(
    parameter int                  ADDR_WIDTH  = 12,
    parameter int                  WDATA_WIDTH = 16,
    parameter int                  RDATA_WIDTH = 32,
    parameter int                  ID_WIDTH    = 2,
    parameter logic [ID_WIDTH-1:0] WR_ID       = ID_WIDTH'(0),
    parameter logic [ID_WIDTH-1:0] RD_ID       = ID_WIDTH'(1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             len_m1,
    input  logic [ADDR_WIDTH-1:0]  wr_base,
    input  logic [ADDR_WIDTH-1:0]  rd_base,
    input  logic                   calc_end,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   src_rd,
    output logic [7:0]             src_addr,
    input  logic [WDATA_WIDTH-1:0] src_data,
    output logic                   dst_we,
    output logic [7:0]             dst_addr,
    output logic [RDATA_WIDTH-1:0] dst_data,
    axi_fft_master_if.master       axi
);

    master_fsm             state_q, state_d;
    logic [7:0]            len_q;
    logic [ADDR_WIDTH-1:0] wr_base_q;
    logic [ADDR_WIDTH-1:0] rd_base_q;
    logic                  err_q;
    logic                  calc_q;
    logic                  done_q;
    logic                  w_entry_q;
    logic [7:0]            rcnt_q;
    logic                  rwrap_q;
    logic                  w_last_hs;
    logic                  r_hs;
    logic                  start_ok;

    assign start_ok = (state_q == M_IDLE) && start;
    assign r_hs     = (state_q == M_R) && axi.rvalid;

    axi_master_wbuf #(.WDATA_WIDTH(WDATA_WIDTH)) u_wbuf (
        .clk      (clk),
        .rst      (rst),
        .entry    (w_entry_q),
        .len_m1   (len_q),
        .wready   (axi.wready),
        .src_data (src_data),
        .wvalid   (axi.wvalid),
        .wdata    (axi.wdata),
        .wlast    (axi.wlast),
        .src_rd   (src_rd),
        .src_addr (src_addr),
        .last_hs  (w_last_hs)
    );

    assign axi.awvalid = (state_q == M_AW);
    assign axi.awaddr  = wr_base_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = SIZE_2B;
    assign axi.awburst = BURST_INCR;
    assign axi.awid    = WR_ID;
    assign axi.wstrb   = '1;
    assign axi.bready  = (state_q == M_B);
    assign axi.arvalid = (state_q == M_AR);
    assign axi.araddr  = rd_base_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = BURST_INCR;
    assign axi.arid    = RD_ID;
    assign axi.rready  = (state_q == M_R);

    // Beats beyond the 256th cannot be addressed, so they are dropped.
    assign dst_we   = r_hs && !rwrap_q;
    assign dst_addr = rcnt_q;
    assign dst_data = axi.rdata;

    assign busy = (state_q != M_IDLE);
    assign done = done_q;
    assign err  = err_q;

    // NOTE: the next-state default is assigned first so no path through the
    // case leaves state_d unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            M_IDLE:  if (start)          state_d = M_AW;
            M_AW:    if (axi.awready)    state_d = M_W;
            M_W:     if (w_last_hs)      state_d = M_B;
            M_B:     if (axi.bvalid)     state_d = M_WAIT;
            M_WAIT:  if (calc_q)         state_d = M_AR;
            M_AR:    if (axi.arready)    state_d = M_R;
            M_R:     if (r_hs && axi.rlast) state_d = M_IDLE;
            default:                     state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= M_IDLE;
            len_q     <= 8'd0;
            wr_base_q <= '0;
            rd_base_q <= '0;
            err_q     <= 1'b0;
            calc_q    <= 1'b0;
            done_q    <= 1'b0;
            w_entry_q <= 1'b0;
            rcnt_q    <= 8'd0;
            rwrap_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= r_hs && axi.rlast;
            w_entry_q <= (state_q == M_AW) && axi.awready;

            if (start_ok) begin
                len_q     <= len_m1;
                wr_base_q <= wr_base;
                rd_base_q <= rd_base;
                err_q     <= 1'b0;
                calc_q    <= 1'b0;
            end else begin
                // An FFT completion seen while still writing is remembered.
                if (calc_end && (state_q inside {M_AW, M_W, M_B, M_WAIT}))
                    calc_q <= 1'b1;
                if ((state_q == M_B) && axi.bvalid && (axi.bid != WR_ID))
                    err_q <= 1'b1;
                if (r_hs && ((axi.rid != RD_ID) || rwrap_q ||
                             (axi.rlast && (rcnt_q != len_q))))
                    err_q <= 1'b1;
            end

            if (state_q == M_AR) begin
                rcnt_q  <= 8'd0;
                rwrap_q <= 1'b0;
            end else if (r_hs) begin
                rcnt_q <= rcnt_q + 8'd1;
                if (rcnt_q == 8'hFF) rwrap_q <= 1'b1;
            end
        end
    end

endmodule
